apb_master_ctrl: RTL and testbench

APB_MASTER_CTRL -- requirements
Module: apb_master_ctrl

---
 rtl/apb_master_ctrl.sv | 101 ++++++++++
 tb/tb_apb_master_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_ctrl.sv
// APB master: turns a valid/ready command stream into APB SETUP/ACCESS transfers,
// with a wait-state timeout and a single-cycle response pulse.
module apb_master_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       CLK,
  input  logic       Rst,
  input  logic       cmd_valid,
  input  logic       cmd_write,
  input  logic [4:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       cmd_ready,
  output logic       PSEL,
  output logic       PENABLE,
  output logic       PWRITE,
  output logic [4:0] PADDR,
  output logic [7:0] PWDATA,
  input  logic       PREADY,
  input  logic [7:0] PRDATA,
  input  logic       PSLVERR,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_error,
  output logic       rsp_timeout
);

  localparam logic [7:0] TimeoutCnt = TIMEOUT[7:0];

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e     state_q;
  logic [7:0] wait_cnt_q;

  // A new command can be taken while idle, or on the completing edge of a transfer.
  assign cmd_ready = !Rst && ((state_q == StIdle) || ((state_q == StAccess) && PREADY));

  always_ff @(posedge CLK) begin
    if (Rst) begin
      state_q     <= StIdle;
      wait_cnt_q  <= 8'd0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= 5'd0;
      PWDATA      <= 8'd0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= 8'd0;
      rsp_error   <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            PWRITE  <= cmd_write;
            PADDR   <= cmd_addr;
            PWDATA  <= cmd_wdata;
            PSEL    <= 1'b1;
            state_q <= StSetup;
          end
        end
        StSetup: begin
          PENABLE    <= 1'b1;
          wait_cnt_q <= 8'd0;
          state_q    <= StAccess;
        end
        StAccess: begin
          // PREADY wins over a coincident timeout match.
          if (PREADY) begin
            rsp_valid   <= 1'b1;
            rsp_error   <= PSLVERR;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= PWRITE ? 8'd0 : PRDATA;
            PENABLE     <= 1'b0;
            if (cmd_valid) begin
              PWRITE  <= cmd_write;
              PADDR   <= cmd_addr;
              PWDATA  <= cmd_wdata;
              state_q <= StSetup;
            end else begin
              PSEL    <= 1'b0;
              state_q <= StIdle;
            end
          end else if (wait_cnt_q == TimeoutCnt) begin
            rsp_valid   <= 1'b1;
            rsp_error   <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_rdata   <= 8'd0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            state_q     <= StIdle;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed bench for apb_master_ctrl built with a short timeout of 4 wait cycles.
module tb_apb_master_ctrl;

  logic       CLK = 1'b0;
  logic       Rst;
  logic       cmd_valid, cmd_write;
  logic [4:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       cmd_ready;
  logic       PSEL, PENABLE, PWRITE;
  logic [4:0] PADDR;
  logic [7:0] PWDATA;
  logic       PREADY;
  logic [7:0] PRDATA;
  logic       PSLVERR;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_error, rsp_timeout;

  int n_cmp = 0;
  int n_err = 0;

  apb_master_ctrl #(.TIMEOUT(4)) dut (
    .CLK        (CLK),
    .Rst        (Rst),
    .cmd_valid  (cmd_valid),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .cmd_ready  (cmd_ready),
    .PSEL       (PSEL),
    .PENABLE    (PENABLE),
    .PWRITE     (PWRITE),
    .PADDR      (PADDR),
    .PWDATA     (PWDATA),
    .PREADY     (PREADY),
    .PRDATA     (PRDATA),
    .PSLVERR    (PSLVERR),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_error  (rsp_error),
    .rsp_timeout(rsp_timeout)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_cmd(input logic v, input logic w, input logic [4:0] a, input logic [7:0] d);
    cmd_valid = v;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
  endtask

  initial begin
    Rst = 1'b1;
    set_cmd(1'b0, 1'b0, 5'd0, 8'd0);
    PREADY = 1'b1; PRDATA = 8'd0; PSLVERR = 1'b0;
    tick(); tick();
    chk("rst_psel", PSEL, 1'b0);
    chk("rst_penable", PENABLE, 1'b0);
    chk("rst_pwrite", PWRITE, 1'b0);
    chk("rst_paddr", PADDR, 5'd0);
    chk("rst_pwdata", PWDATA, 8'd0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_fields", {rsp_rdata, rsp_error, rsp_timeout}, 10'd0);
    chk("rst_cmd_ready", cmd_ready, 1'b0);

    // Write 0x03 <= 0xA5, PREADY tied high.
    Rst = 1'b0;
    set_cmd(1'b1, 1'b1, 5'h03, 8'hA5);
    #1 chk("w_ready_idle", cmd_ready, 1'b1);
    tick();
    chk("w_setup_sel", {PSEL, PENABLE}, 2'b10);
    chk("w_setup_bus", {PWRITE, PADDR, PWDATA}, {1'b1, 5'h03, 8'hA5});
    chk("w_setup_ready", cmd_ready, 1'b0);
    set_cmd(1'b0, 1'b0, 5'h00, 8'h00);
    tick();
    chk("w_access_sel", {PSEL, PENABLE}, 2'b11);
    chk("w_access_ready", cmd_ready, 1'b1);
    chk("w_access_norsp", rsp_valid, 1'b0);
    tick();
    chk("w_rsp", {rsp_valid, rsp_error, rsp_timeout, rsp_rdata}, {3'b100, 8'h00});
    chk("w_idle_sel", {PSEL, PENABLE}, 2'b00);

    // Read 0x03 with two wait states; PRDATA junk while not ready must be ignored.
    set_cmd(1'b1, 1'b0, 5'h03, 8'h00);
    PREADY = 1'b0; PRDATA = 8'hEE;
    tick();
    chk("r_setup_bus", {PWRITE, PADDR}, {1'b0, 5'h03});
    set_cmd(1'b0, 1'b1, 5'h1F, 8'hFF);
    tick();
    chk("r_wait1_sel", {PSEL, PENABLE}, 2'b11);
    #1 chk("r_wait1_ready", cmd_ready, 1'b0);
    chk("r_wait1_addr", PADDR, 5'h03);
    tick();
    chk("r_wait2_addr", {PWRITE, PADDR}, {1'b0, 5'h03});
    chk("r_wait2_norsp", rsp_valid, 1'b0);
    tick();
    PREADY = 1'b1; PRDATA = 8'h5A;
    chk("r_done_addr", PADDR, 5'h03);
    #1 chk("r_done_ready", cmd_ready, 1'b1);
    tick();
    chk("r_rsp", {rsp_valid, rsp_error, rsp_timeout, rsp_rdata}, {3'b100, 8'h5A});
    PRDATA = 8'h77;
    tick();
    chk("r_pulse_end", rsp_valid, 1'b0);
    chk("r_hold_rdata", rsp_rdata, 8'h5A);

    // Back-to-back: write 0x01 <= 0x11 then read 0x01 with no IDLE in between.
    set_cmd(1'b1, 1'b1, 5'h01, 8'h11);
    tick();
    chk("b2b_setup1", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, {3'b101, 5'h01, 8'h11});
    set_cmd(1'b1, 1'b0, 5'h01, 8'h00);
    PRDATA = 8'h3C;
    tick();
    chk("b2b_access1", {PSEL, PENABLE}, 2'b11);
    tick();
    chk("b2b_setup2", {PSEL, PENABLE, PWRITE, PADDR}, {3'b100, 5'h01});
    chk("b2b_rsp1", {rsp_valid, rsp_error, rsp_rdata}, {2'b10, 8'h00});
    set_cmd(1'b0, 1'b0, 5'h00, 8'h00);
    tick();
    chk("b2b_access2", {PSEL, PENABLE}, 2'b11);
    chk("b2b_gap", rsp_valid, 1'b0);
    tick();
    chk("b2b_rsp2", {rsp_valid, rsp_error, rsp_timeout, rsp_rdata}, {3'b100, 8'h3C});
    chk("b2b_idle", PSEL, 1'b0);

    // Slave error on a read.
    set_cmd(1'b1, 1'b0, 5'h02, 8'h00);
    PSLVERR = 1'b1; PRDATA = 8'h99;
    tick();
    set_cmd(1'b0, 1'b0, 5'h00, 8'h00);
    tick(); tick();
    chk("slverr_rsp", {rsp_valid, rsp_error, rsp_timeout, rsp_rdata}, {3'b110, 8'h99});
    PSLVERR = 1'b0;

    // Timeout: PREADY held low; abort after 4 counted wait cycles (5th ACCESS cycle).
    set_cmd(1'b1, 1'b0, 5'h04, 8'h00);
    PREADY = 1'b0;
    tick();
    set_cmd(1'b0, 1'b0, 5'h00, 8'h00);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("to_wait%0d", i), {PSEL, PENABLE, rsp_valid}, 3'b110);
      tick();
    end
    chk("to_rsp", {rsp_valid, rsp_error, rsp_timeout, rsp_rdata}, {3'b111, 8'h00});
    chk("to_idle", {PSEL, PENABLE}, 2'b00);

    // PREADY arriving on the timeout-match cycle completes normally.
    set_cmd(1'b1, 1'b0, 5'h06, 8'h00);
    PRDATA = 8'hC3;
    tick();
    set_cmd(1'b0, 1'b0, 5'h00, 8'h00);
    tick(); tick(); tick(); tick(); tick();
    PREADY = 1'b1;
    chk("race_still_access", {PSEL, PENABLE}, 2'b11);
    tick();
    chk("race_rsp", {rsp_valid, rsp_error, rsp_timeout, rsp_rdata}, {3'b100, 8'hC3});

    // Reset during ACCESS abandons the transfer silently.
    set_cmd(1'b1, 1'b1, 5'h07, 8'h42);
    PREADY = 1'b0;
    tick();
    tick();
    chk("rstmid_access", {PSEL, PENABLE}, 2'b11);
    Rst = 1'b1;
    #1 chk("rstmid_ready_low", cmd_ready, 1'b0);
    tick();
    chk("rstmid_sel", {PSEL, PENABLE}, 2'b00);
    chk("rstmid_norsp", rsp_valid, 1'b0);
    chk("rstmid_bus", {PWRITE, PADDR, PWDATA}, 14'd0);
    Rst = 1'b0;
    set_cmd(1'b1, 1'b0, 5'h08, 8'h00);
    PREADY = 1'b1; PRDATA = 8'h6B;
    #1 chk("post_rst_ready", cmd_ready, 1'b1);
    tick();
    chk("post_rst_setup", {PSEL, PENABLE, PADDR}, {2'b10, 5'h08});
    set_cmd(1'b0, 1'b0, 5'h00, 8'h00);
    tick(); tick();
    chk("post_rst_rsp", {rsp_valid, rsp_error, rsp_timeout, rsp_rdata}, {3'b100, 8'h6B});
    tick();
    chk("post_rst_pulse_end", rsp_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
